// File: rtl/conv3x3_mac_engine.sv
// conv3x3_mac_engine
// Signed 3x3 dot-product engine that sits behind the kernel buffer.
// It accepts one pixel window per beat and sweeps all DEPTH stored kernels
// through o_sel. It emits one result beat per kernel through a 2-stage
// multiply / adder-tree pipeline.
// Optional build macro: CONV_MAC_RELU_EN clamps negative sums to zero.

module conv3x3_mac_engine #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                       i_aclk,
    input  logic                       i_aresetn,
    input  logic                       i_win_tvalid,
    output logic                       o_win_tready,
    input  logic [9*WIDTH-1:0]         i_win_tdata,
    input  logic                       i_buf_valid,
    input  logic [WIDTH-1:0]           i_buf_00,
    input  logic [WIDTH-1:0]           i_buf_01,
    input  logic [WIDTH-1:0]           i_buf_02,
    input  logic [WIDTH-1:0]           i_buf_10,
    input  logic [WIDTH-1:0]           i_buf_11,
    input  logic [WIDTH-1:0]           i_buf_12,
    input  logic [WIDTH-1:0]           i_buf_20,
    input  logic [WIDTH-1:0]           i_buf_21,
    input  logic [WIDTH-1:0]           i_buf_22,
    output logic [$clog2(DEPTH)-1:0]   o_sel,
    output logic                       o_tvalid,
    input  logic                       i_tready,
    output logic [ACC_WIDTH-1:0]       o_tdata,
    output logic                       o_tlast
);

    localparam int SEL_W = $clog2(DEPTH);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                      state;
    logic [9*WIDTH-1:0]          win_reg;
    logic signed [PW-1:0]        s1_prod [9];
    logic                        s1_valid;
    logic                        s1_last;

    logic signed [WIDTH-1:0]     wtap [9];
    logic signed [WIDTH-1:0]     ktap [9];
    logic signed [PW-1:0]        prod_next [9];
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] result;

    logic advance;
    logic win_accept;
    logic sel_last;
    logic issue;

    assign advance      = !o_tvalid || i_tready;
    assign o_win_tready = (state == IDLE) && i_buf_valid;
    assign win_accept   = o_win_tready && i_win_tvalid;
    assign sel_last     = (o_sel == SEL_W'(DEPTH - 1));
    assign issue        = (state == RUN) && advance;

    // Unpack the latched window and the currently selected kernel into tap arrays
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            wtap[i] = win_reg[i*WIDTH +: WIDTH];
        end
        ktap[0] = i_buf_00;
        ktap[1] = i_buf_01;
        ktap[2] = i_buf_02;
        ktap[3] = i_buf_10;
        ktap[4] = i_buf_11;
        ktap[5] = i_buf_12;
        ktap[6] = i_buf_20;
        ktap[7] = i_buf_21;
        ktap[8] = i_buf_22;
        for (int i = 0; i < 9; i++) begin
            prod_next[i] = PW'(wtap[i]) * PW'(ktap[i]);
        end
    end

    // Sign-extended adder tree over the stage-1 products, with optional clamp
    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + ACC_WIDTH'(s1_prod[i]);
        end
`ifdef CONV_MAC_RELU_EN
        result = sum[ACC_WIDTH-1] ? '0 : sum;
`else
        result = sum;
`endif
    end

    // Control FSM: latch a window in IDLE, then walk o_sel across every kernel
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state   <= IDLE;
            o_sel   <= '0;
            win_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_accept) begin
                        win_reg <= i_win_tdata;
                        o_sel   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (sel_last) begin
                            o_sel <= '0;
                            state <= IDLE;
                        end else begin
                            o_sel <= o_sel + SEL_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: register the nine products for the kernel currently selected
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int i = 0; i < 9; i++) begin
                s1_prod[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (advance) begin
            if (issue) begin
                for (int i = 0; i < 9; i++) begin
                    s1_prod[i] <= prod_next[i];
                end
                s1_valid <= 1'b1;
                s1_last  <= sel_last;
            end else begin
                s1_valid <= 1'b0;
                s1_last  <= 1'b0;
            end
        end
    end

    // Stage 2: output register, frozen while the downstream consumer stalls
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else if (advance) begin
            o_tvalid <= s1_valid;
            o_tdata  <= result;
            o_tlast  <= s1_last;
        end
    end

endmodule

// File: doc/conv3x3_mac_engine.md
Name: conv3x3_mac_engine

Overview:
Compute stage directly downstream of the 3x3 kernel buffer. Accepts one 3x3 pixel window per AXI-Stream beat and drives the kernel buffer's select to sweep all DEPTH stored kernels. For each kernel it forms the signed 9-tap dot product in a 2-stage pipeline. Results are emitted on an AXI-Stream master, one beat per kernel (output channel), with TLAST marking the last kernel of each window.

Parameters:
WIDTH, 8, bit width of each pixel and weight (signed two's complement)
DEPTH, 8, number of kernels in the kernel buffer (>=2); o_sel width is $clog2(DEPTH)
ACC_WIDTH, 20, result width; must be >= 2*WIDTH+4 (guaranteed no overflow)

Ports:
i_aclk  in  1  clock; all logic on rising edge
i_aresetn  in  1  asynchronous active-low reset
i_win_tvalid  in  1  window beat valid
o_win_tready  out  1  window beat ready
i_win_tdata  in  9*WIDTH  taps packed row-major; tap 00 in [WIDTH-1:0], tap 22 in MSBs
i_buf_valid  in  1  kernel buffer fully loaded
i_buf_00..i_buf_22  in  WIDTH each  weights of the selected kernel; 9 ports
o_sel  out  $clog2(DEPTH)  kernel select to the buffer
o_tvalid  out  1  result valid
i_tready  in  1  result ready
o_tdata  out  ACC_WIDTH  signed dot product
o_tlast  out  1  high on the result for kernel DEPTH-1

Behaviour:
- Reset values: state IDLE, o_sel=0, o_tvalid=0, o_tdata=0, o_tlast=0, stage-1 valid=0, window register=0.
- Kernel taps are a combinational function of o_sel; the engine samples them in the same cycle o_sel presents the index.
- o_win_tready = (state==IDLE) && i_buf_valid, combinational from registered state.
- advance = !o_tvalid || i_tready; when advance is low, the FSM, o_sel, stage 1 and the output register all hold.
- IDLE: on a window handshake, latch i_win_tdata; set o_sel=0; go to RUN. Window acceptance in IDLE is allowed during an output stall.
- RUN, each advance cycle:
  - stage 1 registers the 9 signed WIDTH x WIDTH products (2*WIDTH bits each), valid=1, and tags last=(o_sel==DEPTH-1).
  - If o_sel==DEPTH-1: o_sel returns to 0 and state returns to IDLE.
  - Otherwise o_sel increments.
- Stage 2, on advance: sign-extended adder tree of the stage-1 products into o_tdata; o_tvalid=stage-1 valid; o_tlast=stage-1 last. Stage-1 valid clears when no new issue occurs.
- Latency: accepting edge E0 -> kernel 0 issued cycle after E0 -> o_tvalid for kernel 0 visible after E2. Unstalled rate is 1 result/cycle.
- Throughput: next window is accepted at the earliest one cycle after the last issue (DEPTH+1 cycles/window).
- AXI rules: o_tdata/o_tlast stable while o_tvalid && !i_tready; o_tvalid never drops without a handshake.
- i_buf_valid falling during RUN is ignored; the current window completes. The system reloads kernels only while the engine is idle.
- Exactly DEPTH beats are produced per window, in kernel order 0..DEPTH-1.
- Asynchronous reset mid-operation flushes everything: in-flight results are discarded and no beat appears until a new window is accepted.

Optional Feature:
CONV_MAC_RELU_EN
- Defined: stage 2 clamps negative sums to 0 before the output register; latency unchanged.
- Undefined: the raw signed sum is output.

Test Plan:
- WIDTH=8, DEPTH=8; kernel k taps all k+1; window taps all 1; i_tready=1 -> o_tdata 9,18,...,72 on consecutive cycles; o_tlast only on 72; first o_tvalid 2 edges after the accepting edge.
- Window taps all -128, kernel taps all -128 -> every result 147456 (0x24000); no overflow.
- Window taps all -1, kernel taps all 5 -> every result -45 (0xFFFD3); with CONV_MAC_RELU_EN -> 0.
- After the first result, i_tready=0 for 3 cycles -> o_tdata held at 9, o_sel frozen; after release, 18..72 follow with no loss or duplication.
- Two windows back-to-back with i_win_tvalid held high -> 16 beats with a 1-cycle gap between beat 8 and beat 9; o_win_tready low throughout RUN; i_buf_valid=0 -> o_win_tready=0 and no acceptance.
- Assert i_aresetn=0 after 3 results -> o_tvalid/o_tdata/o_tlast/o_sel = 0 immediately; no further beats until a new window is accepted.
